// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: line mux select encodings, sequencer state encoding
// and the bit-counter width helper.
package uart_tx_pkg;

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Counter width for a count of n bits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Serial bit counter with synchronous clear and enable; flags the last bit of a
// COUNT-bit word and folds back to zero after it. Shared by the TX and RX paths.
module uart_tx_bit_cnt
  import uart_tx_pkg::*;
#(
  parameter int unsigned COUNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == LAST);

  // Folding back at LAST keeps the count inside 0..COUNT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, DATA_WIDTH data bits, optional parity,
// stop bit; one bit per CLK cycle, back-to-back frames accepted from STOP.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       data_valid,
  input  logic       par_en,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  tx_state_e state_q, state_d;
  logic      par_en_q;
  logic      cnt_clr, cnt_en, last_bit;

  uart_tx_bit_cnt #(
    .COUNT (DATA_WIDTH)
  ) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parity enable is frozen for the whole frame at the accept edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q <= 1'b0;
    end else if (ser_load) begin
      par_en_q <= par_en;
    end
  end

  // Next state and Moore decode; ser_load is the only input-dependent output.
  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_en   = 1'b0;
    mux_sel  = MUX_STOP;
    busy     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (data_valid && RST) begin
          ser_load = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        mux_sel = MUX_START;
        busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        busy    = 1'b1;
        cnt_en  = 1'b1;
        if (last_bit) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        mux_sel = MUX_PARITY;
        busy    = 1'b1;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        busy = 1'b1;
        if (data_valid && RST) begin
          ser_load = 1'b1;
          state_d  = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl at DATA_WIDTH 8 and 5, driven in parallel
// and compared every cycle against a frame-position model.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       sl  [2];
  logic       se  [2];
  logic       bsy [2];
  logic [1:0] mux [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst_n), .data_valid(data_valid), .par_en(par_en),
    .ser_load(sl[0]), .ser_en(se[0]), .mux_sel(mux[0]), .busy(bsy[0])
  );

  uart_tx_ctrl #(.DATA_WIDTH(5)) u_dut5 (
    .CLK(clk), .RST(rst_n), .data_valid(data_valid), .par_en(par_en),
    .ser_load(sl[1]), .ser_en(se[1]), .mux_sel(mux[1]), .busy(bsy[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the current frame (-1 = idle) and frame length.
  int ph   [2] = '{-1, -1};
  int plen [2] = '{0, 0};

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  function automatic bit can_accept(input int i);
    return (ph[i] < 0) || (ph[i] == plen[i] - 1);
  endfunction

  function automatic int exp_mux(input int i);
    if (ph[i] < 0)              return 1;
    if (ph[i] == 0)             return 0;
    if (ph[i] <= wd(i))         return 2;
    if (ph[i] == plen[i] - 1)   return 1;
    return 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ph[i] <= -1;
      end else if (can_accept(i)) begin
        if (data_valid) begin
          ph[i]   <= 0;
          plen[i] <= 2 + wd(i) + (par_en ? 1 : 0);
        end else begin
          ph[i] <= -1;
        end
      end else begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("mux_sel[w%0d]", wd(i)), int'(mux[i]), exp_mux(i));
      check($sformatf("ser_en[w%0d]", wd(i)), int'(se[i]),
            (ph[i] >= 1 && ph[i] <= wd(i)) ? 1 : 0);
      check($sformatf("busy[w%0d]", wd(i)), int'(bsy[i]), (ph[i] >= 0) ? 1 : 0);
      check($sformatf("ser_load[w%0d]", wd(i)), int'(sl[i]),
            (rst_n && data_valid && can_accept(i)) ? 1 : 0);
    end
  end

  // One-cycle request, par_en flipped mid-frame; pins frame shape to literals.
  task automatic pulse_frame(input bit pe);
    int n_sl [2];
    int n_se [2];
    int n_b  [2];
    int mux1 [2];
    for (int i = 0; i < 2; i++) begin
      n_sl[i] = 0; n_se[i] = 0; n_b[i] = 0; mux1[i] = -1;
    end
    @(posedge clk); #1;
    data_valid = 1'b1;
    par_en     = pe;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_sl[i] += int'(sl[i]);
        n_se[i] += int'(se[i]);
        n_b[i]  += int'(bsy[i]);
        if (c == 1) mux1[i] = int'(mux[i]);
      end
      if (c == 0) begin
        @(posedge clk); #1;
        data_valid = 1'b0;
      end
      if (c == 4) begin
        #1 par_en = ~par_en;
      end
    end
    check("frame_sl_cnt_w8", n_sl[0], 1);
    check("frame_sl_cnt_w5", n_sl[1], 1);
    check("frame_se_cnt_w8", n_se[0], 8);
    check("frame_se_cnt_w5", n_se[1], 5);
    check("frame_busy_w8", n_b[0], pe ? 11 : 10);
    check("frame_busy_w5", n_b[1], pe ? 8 : 7);
    check("first_bit_start_w8", mux1[0], 0);
    check("first_bit_start_w5", mux1[1], 0);
  endtask

  initial begin
    int n_sl, n_b;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("idle_mux", int'(mux[0]), 1);
    check("idle_busy", int'(bsy[0]), 0);

    pulse_frame(1'b0);
    pulse_frame(1'b1);

    // Continuous request: no idle gap, loads only on accept and in STOP.
    n_sl = 0; n_b = 0;
    @(posedge clk); #1;
    data_valid = 1'b1;
    par_en     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_sl += int'(sl[0]);
      n_b  += int'(bsy[0]);
    end
    check("b2b_sl_cnt_w8", n_sl, 4);
    check("b2b_busy_w8", n_b, 39);
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (14) @(posedge clk);

    // Asynchronous reset during the 4th data bit of the 8-bit frame.
    #1 data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (4) @(posedge clk);
    check("pre_reset_data_w8", int'(mux[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mux_w8", int'(mux[0]), 1);
    check("rst_busy_w8", int'(bsy[0]), 0);
    check("rst_ser_en_w8", int'(se[0]), 0);
    check("rst_mux_w5", int'(mux[1]), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_frame(1'b0);

    // Randomized requests and parity enables.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      data_valid = ($urandom_range(0, 3) != 0);
      par_en     = $urandom_range(0, 1) != 0;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. Accepts a load request, then steps the TX output multiplexer through start bit, DATA_WIDTH serial data bits, an optional parity bit, and a stop bit. It also drives the serializer's load/shift enables and reports busy to the upstream register file/FIFO reader. One bit period equals one CLK cycle; CLK is the TX bit clock.

Parameters:
DATA_WIDTH, 8, number of serial data bits per frame (legal range 5..9)

Ports:
CLK  input  1  TX bit clock, rising-edge
RST  input  1  asynchronous active-low reset
data_valid  input  1  request to send a frame; parallel data is presented to the serializer in the same cycle
par_en  input  1  parity bit enable; sampled only when a request is accepted
ser_load  output  1  combinational pulse; serializer/parity calculator capture parallel data at this edge
ser_en  output  1  serializer shift enable, one data bit per cycle
mux_sel  output  2  TX mux select: 00 start, 01 stop/idle, 10 serial data, 11 parity
busy  output  1  frame in progress; upstream must not change data while high

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, bit_cnt=0, par_en_q=0; outputs mux_sel=01 (line idles high), ser_en=0, ser_load=0, busy=0. Reset mid-frame aborts immediately; the line returns high in the same cycle. No partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP; Moore decode for mux_sel/ser_en/busy from the state register.
- IDLE: mux_sel=01, busy=0, ser_en=0. data_valid=1 -> accept: ser_load=1 (same cycle, combinational), par_en_q<=par_en, next START.
- START: mux_sel=00, busy=1, 1 cycle -> DATA, bit_cnt<=0.
- DATA: mux_sel=10, ser_en=1, busy=1. bit_cnt increments each cycle. At bit_cnt==DATA_WIDTH-1: next PARITY if par_en_q=1, else STOP; bit_cnt<=0.
- PARITY: mux_sel=11, busy=1, 1 cycle -> STOP.
- STOP: mux_sel=01, busy=1. If data_valid=1: accept back-to-back (ser_load=1, par_en_q<=par_en, next START, no idle gap). Otherwise next IDLE.
- Latency: data_valid accepted at edge k -> start bit on line during cycle k+1; frame length 1+DATA_WIDTH+par+1 cycles (10 or 11 at default).
- data_valid in START/DATA/PARITY is ignored and produces no ser_load. Upstream holds or re-asserts the request.
- par_en changes during a frame have no effect; only the latched par_en_q is used.
- bit_cnt width is $clog2(DATA_WIDTH). The counter never wraps past DATA_WIDTH-1.
- Unreachable state encodings go to IDLE with the idle outputs.
- ser_load is the only Mealy output. All others are decoded from registered state.

Decomposition:
- Shared package uart_tx_pkg: mux_sel encodings (MUX_START=2'b00, MUX_STOP=2'b01, MUX_DATA=2'b10, MUX_PARITY=2'b11) and the state enum encoding. The TX mux uses the same constants.
- One sub-module: uart_tx_bit_cnt (clear/enable counter with terminal-count flag at DATA_WIDTH-1), reusable by the RX side. The FSM stays in uart_tx_ctrl.

Test Plan:
- Reset then idle 5 cycles, data_valid=0 -> mux_sel=01, busy=0, ser_en=0 throughout.
- data_valid=1 for 1 cycle, par_en=0, DATA_WIDTH=8 -> ser_load pulse in the accept cycle; mux_sel sequence 00, 10x8, 01; ser_en high exactly 8 cycles; busy high 10 cycles; then IDLE.
- Same with par_en=1 -> mux_sel 00, 10x8, 11, 01; busy high 11 cycles. par_en toggled mid-frame -> sequence unchanged.
- data_valid held high continuously, par_en=0 -> back-to-back frames with no idle cycle; ser_load only in the STOP cycles (and the first accept); data_valid during DATA produces no ser_load.
- RST asserted asynchronously during the 4th data bit -> mux_sel=01, busy=0, ser_en=0 immediately. After release with data_valid=1, a full fresh 10-cycle frame follows.
- DATA_WIDTH=5, par_en=1 -> ser_en high 5 cycles, total frame 8 cycles.
